// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master (plus the HREADY interconnect) and the SRAM slave.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    // HREADY belongs to the interconnect, so it sits on the master/bus side here.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a word-organised RAM: byte/half/word access, programmable wait
// states, two-cycle ERROR response and write-to-read forwarding.
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic            CLK,
    input  logic            nRST,
    ahb_sram_slave_if.slave bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [1:0]    lo;
        logic [2:0]    size;
        logic          write;
    } aphase_t;

    state_t      state;
    aphase_t     lat;
    logic        dp_valid;
    logic [3:0]  cnt;
    logic        hreadyout_q;
    logic        hresp_q;
    logic [31:0] hrdata_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          accept;
    logic          in_range;
    logic          misaligned;
    logic          illegal;
    logic [IW-1:0] idx_in;
    logic          wr_commit;
    logic [3:0]    wr_be;
    logic [31:0]   wr_word;
    logic          unused_ok;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'b000:  lane_mask = 4'b0001 << lo;
            3'b001:  lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            merge[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    endfunction

    assign offset     = bus.HADDR - BASE_ADDR;
    assign in_range   = (bus.HADDR >= BASE_ADDR) && ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
    assign misaligned = ((bus.HSIZE == 3'b001) && bus.HADDR[0]) ||
                        ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
    assign illegal    = (bus.HSIZE > 3'b010) || misaligned || !in_range;
    assign accept     = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign idx_in     = offset[IW+1:2];
    assign unused_ok  = ^{bus.HTRANS[0], offset[1:0]};

    // The write lands at the edge ending its completion cycle; a read accepted on that
    // same edge must see the merged word, hence the bypass in fetch().
    assign wr_commit = dp_valid && lat.write && (state == S_IDLE);
    assign wr_be     = lane_mask(lat.size, lat.lo);
    assign wr_word   = merge(mem[lat.idx], bus.HWDATA, wr_be);

    function automatic logic [31:0] fetch(input logic [IW-1:0] idx);
        fetch = (wr_commit && (idx == lat.idx)) ? wr_word : mem[idx];
    endfunction

    // NOTE: the RAM is cleared by reset, so it is a resettable register array rather than
    // an inferred SRAM macro; a macro-backed variant would need a clear sequencer instead.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (wr_commit) begin
            mem[lat.idx] <= wr_word;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every read in
    // this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_IDLE;
            lat         <= '0;
            dp_valid    <= 1'b0;
            cnt         <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            hrdata_q <= '0;
            case (state)
                S_IDLE, S_ERR2: begin
                    state       <= S_IDLE;
                    dp_valid    <= 1'b0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    if (accept) begin
                        if (illegal) begin
                            state       <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else begin
                            dp_valid <= 1'b1;
                            lat      <= '{idx: idx_in, lo: bus.HADDR[1:0],
                                          size: bus.HSIZE, write: bus.HWRITE};
                            if (WAIT_STATES == 0) begin
                                if (!bus.HWRITE) hrdata_q <= fetch(idx_in);
                            end else begin
                                state       <= S_WAIT;
                                cnt         <= 4'(WAIT_STATES);
                                hreadyout_q <= 1'b0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        if (!lat.write) hrdata_q <= fetch(lat.idx);
                    end
                end
                S_ERR1: begin
                    state       <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.HRDATA    = hrdata_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: a zero-wait and a three-wait-state slave on one shared master,
// with a memory model feeding a queue of expected data-phase results.
module tb_ahb_sram_slave;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          WS0   = 0;
    localparam int          WS1   = 3;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        resp;
        logic [7:0]  cycles;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int active = 0;
    logic        hready_force = 1'b0;
    logic        sel_d   = 1'b0;
    logic [1:0]  trans_d = T_IDLE;
    logic        write_d = 1'b0;
    logic [2:0]  size_d  = 3'b000;
    logic [31:0] addr_d  = '0;
    logic [31:0] wdata_d = '0;
    logic        hready;

    txn_t        stim_q[$];
    exp_t        sb_q[$];
    logic [31:0] model [2][DEPTH];
    int          errors = 0;
    int          checks = 0;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();

    assign hready = hready_force ? 1'b0 : ((active == 0) ? bus0.HREADYOUT : bus1.HREADYOUT);

    assign bus0.HSEL   = sel_d && (active == 0);
    assign bus0.HADDR  = addr_d;
    assign bus0.HTRANS = trans_d;
    assign bus0.HWRITE = write_d;
    assign bus0.HSIZE  = size_d;
    assign bus0.HWDATA = wdata_d;
    assign bus0.HREADY = hready;
    assign bus1.HSEL   = sel_d && (active == 1);
    assign bus1.HADDR  = addr_d;
    assign bus1.HTRANS = trans_d;
    assign bus1.HWRITE = write_d;
    assign bus1.HSIZE  = size_d;
    assign bus1.HWDATA = wdata_d;
    assign bus1.HREADY = hready;

    ahb_sram_slave #(.BASE_ADDR(BASE0), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .CLK (clk),
        .nRST(rst_n),
        .bus (bus0.slave)
    );

    ahb_sram_slave #(.BASE_ADDR(BASE1), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .CLK (clk),
        .nRST(rst_n),
        .bus (bus1.slave)
    );

    task automatic add(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.sel = sel; t.trans = tr; t.write = wr; t.size = sz; t.addr = a; t.wdata = wd;
        stim_q.push_back(t);
    endtask

    task automatic drive(input txn_t t);
        sel_d = t.sel; trans_d = t.trans; write_d = t.write; size_d = t.size; addr_d = t.addr;
    endtask

    task automatic drive_idle();
        sel_d = 1'b0; trans_d = T_IDLE; write_d = 1'b0; size_d = 3'b000; addr_d = '0;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
    endtask

    // Reference behaviour of one transfer, applied to the model in bus order.
    task automatic predict(input txn_t t, output exp_t e);
        logic [31:0] base;
        logic [31:0] off;
        int          lo;
        int          nbytes;
        int          idx;
        bit          bad;
        base     = (active == 0) ? BASE0 : BASE1;
        e.addr   = t.addr;
        e.rdata  = '0;
        e.resp   = 1'b0;
        e.cycles = 8'd1;
        if (t.sel && t.trans[1]) begin
            off    = t.addr - base;
            lo     = int'(t.addr[1:0]);
            nbytes = 1 << t.size;
            bad    = (t.size > 3'd2) || (t.addr < base) || (off >= 32'(4 * DEPTH)) ||
                     ((t.size == 3'd1) && t.addr[0]) || ((t.size == 3'd2) && (lo != 0));
            if (bad) begin
                e.resp   = 1'b1;
                e.cycles = 8'd2;
            end else begin
                idx      = int'(off >> 2);
                e.cycles = 8'(((active == 0) ? WS0 : WS1) + 1);
                if (t.write) begin
                    for (int b = 0; b < 4; b++)
                        if (b >= lo && b < lo + nbytes)
                            model[active][idx][8*b +: 8] = t.wdata[8*b +: 8];
                end else begin
                    e.rdata = model[active][idx];
                end
            end
        end
    endtask

    // Pipelined master: issues queued address phases, scores every data phase.
    task automatic run_stim(input string tag);
        txn_t        cur;
        exp_t        e;
        bit          dp_active = 0;
        int          dp_cycles = 0;
        logic [31:0] dp_wdata  = '0;
        int          guard     = 0;
        logic        rdy;
        logic        rsp;
        logic [31:0] rd;
        while (stim_q.size() > 0 || dp_active) begin
            @(posedge clk); #1;
            if (stim_q.size() > 0) drive(stim_q[0]);
            else drive_idle();
            wdata_d = dp_wdata;
            @(negedge clk);
            rdy = hready;
            rsp = (active == 0) ? bus0.HRESP  : bus1.HRESP;
            rd  = (active == 0) ? bus0.HRDATA : bus1.HRDATA;
            if (dp_active) begin
                dp_cycles++;
                if (rdy) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (rd !== e.rdata) begin
                        errors++;
                        $display("FAIL %s rdata @%h: got %h expected %h", tag, e.addr, rd, e.rdata);
                    end
                    checks++;
                    if (rsp !== e.resp) begin
                        errors++;
                        $display("FAIL %s hresp @%h: got %b expected %b", tag, e.addr, rsp, e.resp);
                    end
                    checks++;
                    if (dp_cycles != int'(e.cycles)) begin
                        errors++;
                        $display("FAIL %s length @%h: got %0d cycles expected %0d", tag, e.addr,
                                 dp_cycles, e.cycles);
                    end
                    dp_active = 0;
                end else begin
                    checks++;
                    if (rsp !== sb_q[0].resp || rd !== 32'h0) begin
                        errors++;
                        $display("FAIL %s stall @%h: got resp=%b rdata=%h expected resp=%b rdata=0",
                                 tag, sb_q[0].addr, rsp, rd, sb_q[0].resp);
                    end
                end
            end
            if (rdy && stim_q.size() > 0) begin
                cur = stim_q.pop_front();
                predict(cur, e);
                sb_q.push_back(e);
                dp_active = 1;
                dp_cycles = 0;
                dp_wdata  = cur.wdata;
            end
            guard++;
            if (guard > 300) begin
                errors++;
                $display("FAIL %s timeout: got %0d cycles expected completion", tag, guard);
                stim_q.delete();
                sb_q.delete();
                break;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int d);
        logic        rdy;
        logic        rsp;
        logic [31:0] rd;
        rdy = (d == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
        rsp = (d == 0) ? bus0.HRESP     : bus1.HRESP;
        rd  = (d == 0) ? bus0.HRDATA    : bus1.HRDATA;
        checks++;
        if (rdy !== 1'b1) begin
            errors++; $display("FAIL %s dut%0d hreadyout: got %b expected 1", tag, d, rdy);
        end
        checks++;
        if (rsp !== 1'b0) begin
            errors++; $display("FAIL %s dut%0d hresp: got %b expected 0", tag, d, rsp);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL %s dut%0d hrdata: got %h expected 0", tag, d, rd);
        end
    endtask

    task automatic test_reset();
        clear_model();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_held", 0);
        check_idle_outputs("reset_held", 1);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_released", 0);
        check_idle_outputs("reset_released", 1);
    endtask

    task automatic test_word_rw();
        active = 0;
        add(1, T_NSEQ, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        add(1, T_NSEQ, 0, 3'd2, 32'h10, 32'h0);
        add(1, T_NSEQ, 1, 3'd2, 32'h14, 32'h0102_0304);
        add(1, T_SEQ,  0, 3'd2, 32'h14, 32'h0);
        add(1, T_NSEQ, 0, 3'd2, 32'h10, 32'h0);
        run_stim("word_rw");
    endtask

    task automatic test_byte_half();
        active = 0;
        add(1, T_NSEQ, 1, 3'd2, 32'h10, 32'h1122_3344);
        add(1, T_NSEQ, 1, 3'd0, 32'h13, 32'hAA00_0000);
        add(1, T_NSEQ, 0, 3'd2, 32'h10, 32'h0);
        add(1, T_NSEQ, 1, 3'd1, 32'h12, 32'h5566_0000);
        add(1, T_NSEQ, 0, 3'd2, 32'h10, 32'h0);
        add(1, T_NSEQ, 1, 3'd0, 32'h19, 32'h0000_BB00);
        add(1, T_NSEQ, 1, 3'd1, 32'h18, 32'h0000_7788);
        add(1, T_NSEQ, 0, 3'd0, 32'h18, 32'h0);
        run_stim("byte_half");
    endtask

    task automatic test_wait_states();
        active = 1;
        add(1, T_NSEQ, 1, 3'd2, BASE1 + 32'h8, 32'hCAFE_F00D);
        add(1, T_NSEQ, 0, 3'd2, BASE1 + 32'h8, 32'h0);
        add(1, T_NSEQ, 0, 3'd2, BASE1 + 32'hC, 32'h0);
        add(1, T_NSEQ, 1, 3'd0, BASE1 + 32'h9, 32'h0000_5A00);
        add(1, T_SEQ,  0, 3'd2, BASE1 + 32'h8, 32'h0);
        run_stim("wait_states");
    endtask

    task automatic test_errors();
        active = 0;
        add(1, T_NSEQ, 0, 3'd2, 32'h2,             32'h0);
        add(1, T_NSEQ, 0, 3'd1, 32'h11,            32'h0);
        add(1, T_NSEQ, 0, 3'd3, 32'h10,            32'h0);
        add(1, T_NSEQ, 0, 3'd2, BASE0 + 4 * DEPTH, 32'h0);
        add(1, T_NSEQ, 1, 3'd2, 32'h2,             32'hFFFF_FFFF);
        add(1, T_NSEQ, 1, 3'd2, BASE0 + 4 * DEPTH, 32'hFFFF_FFFF);
        add(1, T_NSEQ, 0, 3'd2, 32'h0,             32'h0);
        add(1, T_NSEQ, 0, 3'd2, 32'h10,            32'h0);
        run_stim("errors_ws0");
        active = 1;
        add(1, T_NSEQ, 0, 3'd2, BASE1 - 32'h4,             32'h0);
        add(1, T_NSEQ, 1, 3'd2, BASE1 + 4 * DEPTH - 4,     32'h7777_8888);
        add(1, T_NSEQ, 0, 3'd2, BASE1 + 4 * DEPTH,         32'h0);
        add(1, T_NSEQ, 0, 3'd2, BASE1 + 4 * DEPTH - 4,     32'h0);
        run_stim("errors_ws3");
    endtask

    task automatic test_idle_busy();
        active = 0;
        add(1, T_IDLE, 1, 3'd2, 32'h20, 32'h1234_5678);
        add(1, T_BUSY, 1, 3'd2, 32'h20, 32'h1234_5678);
        add(0, T_NSEQ, 1, 3'd2, 32'h20, 32'h1234_5678);
        add(1, T_NSEQ, 0, 3'd2, 32'h20, 32'h0);
        add(1, T_NSEQ, 1, 3'd2, 32'h24, 32'h0BAD_F00D);
        add(1, T_BUSY, 0, 3'd2, 32'h24, 32'h0);
        add(0, T_SEQ,  0, 3'd2, 32'h24, 32'h0);
        add(1, T_SEQ,  0, 3'd2, 32'h24, 32'h0);
        run_stim("idle_busy");
    endtask

    task automatic test_hready_low();
        txn_t t;
        active = 0;
        t.sel = 1'b1; t.trans = T_NSEQ; t.write = 1'b1; t.size = 3'd2;
        t.addr = 32'h30; t.wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        hready_force = 1'b1;
        drive(t);
        wdata_d = t.wdata;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("hready_low", 0);
        end
        @(posedge clk); #1;
        hready_force = 1'b0;
        drive_idle();
        add(1, T_NSEQ, 0, 3'd2, 32'h30, 32'h0);
        run_stim("hready_low_readback");
    endtask

    task automatic test_reset_mid();
        active = 1;
        add(1, T_NSEQ, 1, 3'd2, BASE1 + 32'h40, 32'h1111_1111);
        run_stim("reset_mid_setup");
        @(posedge clk); #1;
        sel_d = 1'b1; trans_d = T_NSEQ; write_d = 1'b1; size_d = 3'd2; addr_d = BASE1 + 32'h40;
        @(posedge clk); #1;
        drive_idle();
        wdata_d = 32'h2222_2222;
        @(negedge clk);
        checks++;
        if (bus1.HREADYOUT !== 1'b0) begin
            errors++; $display("FAIL reset_mid wait: got hreadyout=%b expected 0", bus1.HREADYOUT);
        end
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async", 1);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add(1, T_NSEQ, 0, 3'd2, BASE1 + 32'h40, 32'h0);
        run_stim("reset_mid_readback");
        active = 0;
        add(1, T_NSEQ, 0, 3'd2, 32'h10, 32'h0);
        run_stim("reset_mid_ws0");
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_wait_states();
        test_errors();
        test_idle_busy();
        test_hready_low();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
